// File: rtl/psg_write_arbiter.sv
// Two-requester arbiter for the SN76489 write port. A requester keeps the port for a whole
// multi-byte command, strobes are spaced WRITE_GAP cycles apart, and a stalled owner is released.
module psg_write_arbiter #(
    parameter int WRITE_GAP    = 16,
    parameter int TIMEOUT_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    input  logic       a_last,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    input  logic       b_last,
    output logic       b_ready,
    output logic [7:0] psg_data,
    output logic       psg_we,
    output logic [1:0] grant,
    output logic       err_no_latch,
    output logic       err_timeout
);

    localparam int GAP_W = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WRITE_GAP - 1);
    localparam logic [TIMEOUT_BITS-1:0] STALL_MAX = '1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic                    last_b_q, last_b_d;
    logic                    first_q, first_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [TIMEOUT_BITS-1:0] stall_q, stall_d;
    logic [7:0]              data_q, data_d;
    logic                    we_q, we_d;
    logic                    enl_q, enl_d;
    logic                    eto_q, eto_d;

    logic       gap_clear;
    logic       own_valid;
    logic [7:0] own_data;
    logic       own_last;
    logic       accept;

    // Handshake: a byte moves on the rising edge where valid and ready are both high. ready depends
    // only on registered state (owner, gap counter), so a requester may look at it before deciding.
    assign gap_clear = (gap_q == '0);
    assign a_ready   = (state_q == LOCKED) && grant_q[0] && gap_clear;
    assign b_ready   = (state_q == LOCKED) && grant_q[1] && gap_clear;
    assign own_valid = grant_q[1] ? b_valid : (grant_q[0] ? a_valid : 1'b0);
    assign own_data  = grant_q[1] ? b_data : a_data;
    assign own_last  = grant_q[1] ? b_last : a_last;
    assign accept    = (a_valid && a_ready) || (b_valid && b_ready);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_b_d = last_b_q;
        first_d  = first_q;
        gap_d    = gap_clear ? gap_q : gap_q - 1'b1;
        stall_d  = stall_q;
        data_d   = data_q;
        we_d     = 1'b0;
        enl_d    = 1'b0;
        eto_d    = 1'b0;

        case (state_q)
            IDLE: begin
                stall_d = '0;
                // On a tie the requester that did not own the port last time wins.
                if (a_valid && (!b_valid || last_b_q)) begin
                    grant_d = 2'b01;
                    state_d = LOCKED;
                end else if (b_valid) begin
                    grant_d = 2'b10;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept) begin
                    stall_d = '0;
                    if (first_q && !own_data[7]) begin
                        enl_d = 1'b1;
                    end else begin
                        data_d  = own_data;
                        we_d    = 1'b1;
                        gap_d   = GAP_LOAD;
                        first_d = 1'b0;
                    end
                    if (own_last) begin
                        state_d  = IDLE;
                        grant_d  = 2'b00;
                        last_b_d = grant_q[1];
                        first_d  = 1'b1;
                    end
                end else if (!own_valid && gap_clear) begin
                    // Only cycles in which the owner could have sent a byte count as stalled.
                    if (stall_q == STALL_MAX - 1'b1) begin
                        stall_d  = '0;
                        eto_d    = 1'b1;
                        state_d  = IDLE;
                        grant_d  = 2'b00;
                        last_b_d = grant_q[1];
                        first_d  = 1'b1;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            last_b_q <= 1'b1;
            first_q  <= 1'b1;
            gap_q    <= '0;
            stall_q  <= '0;
            data_q   <= 8'h00;
            we_q     <= 1'b0;
            enl_q    <= 1'b0;
            eto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_b_q <= last_b_d;
            first_q  <= first_d;
            gap_q    <= gap_d;
            stall_q  <= stall_d;
            data_q   <= data_d;
            we_q     <= we_d;
            enl_q    <= enl_d;
            eto_q    <= eto_d;
        end
    end

    assign psg_data     = data_q;
    assign psg_we       = we_q;
    assign grant        = grant_q;
    assign err_no_latch = enl_q;
    assign err_timeout  = eto_q;

endmodule
